apb_timer_arbiter: RTL and testbench

APB_TIMER_ARBITER -- requirements
Module: apb_timer_arbiter

---
 rtl/apb_timer_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_apb_timer_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_arbiter.sv
// ============================================================================
// Module      : apb_timer_arbiter
// Description : Two-requester round-robin APB arbiter in front of a timer unit,
//               with an ACCESS-phase timeout that answers the requester with an error.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module apb_timer_arbiter #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    // requester 0
    input  logic                  s0_psel,
    input  logic                  s0_penable,
    input  logic                  s0_pwrite,
    input  logic [ADDR_WIDTH-1:0] s0_paddr,
    input  logic [DATA_WIDTH-1:0] s0_pwdata,
    output logic                  s0_pready,
    output logic                  s0_pslverr,
    output logic [DATA_WIDTH-1:0] s0_prdata,
    // requester 1
    input  logic                  s1_psel,
    input  logic                  s1_penable,
    input  logic                  s1_pwrite,
    input  logic [ADDR_WIDTH-1:0] s1_paddr,
    input  logic [DATA_WIDTH-1:0] s1_pwdata,
    output logic                  s1_pready,
    output logic                  s1_pslverr,
    output logic [DATA_WIDTH-1:0] s1_prdata,
    // shared port to the timer unit
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [ADDR_WIDTH-1:0] m_paddr,
    output logic [DATA_WIDTH-1:0] m_pwdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr,
    input  logic [DATA_WIDTH-1:0] m_prdata,
    // status
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic                  last_q,    last_d;
    logic [1:0]            grant_q,   grant_d;
    logic                  write_q,   write_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  slverr_q,  slverr_d;
    logic                  timeout_q, timeout_d;

    logic                  w_pick1;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_busy;
    logic                  w_resp;
    logic                  w_unused;

    // Requesters follow a psel-held handshake; their penable carries no extra information.
    assign w_unused = s0_penable ^ s1_penable;

    // last_q holds the index of the requester served most recently.
    assign w_pick1   = s1_psel && (!s0_psel || !last_q);
    assign w_cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_psel || s1_psel) begin
                    grant_d = w_pick1 ? 2'b10 : 2'b01;
                    write_d = w_pick1 ? s1_pwrite : s0_pwrite;
                    addr_d  = w_pick1 ? s1_paddr  : s0_paddr;
                    wdata_d = w_pick1 ? s1_pwdata : s0_pwdata;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (m_pready) begin
                    rdata_d  = write_q ? '0 : m_prdata;
                    slverr_d = m_pslverr;
                    state_d  = RESP;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                        rdata_d   = '0;
                        slverr_d  = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                last_d   = grant_q[1];
                grant_d  = 2'b00;
                rdata_d  = '0;
                slverr_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            grant_q   <= 2'b00;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            timeout_q <= timeout_d;
        end
    end

    // All outputs decode from registered state only, so nothing combinational crosses the block.
    assign w_busy    = (state_q == SETUP) || (state_q == ACCESS);
    assign w_resp    = (state_q == RESP);

    assign m_psel    = w_busy;
    assign m_penable = (state_q == ACCESS);
    assign m_pwrite  = w_busy & write_q;
    assign m_paddr   = w_busy ? addr_q  : '0;
    assign m_pwdata  = w_busy ? wdata_q : '0;

    assign s0_pready  = w_resp & grant_q[0];
    assign s0_pslverr = s0_pready & slverr_q;
    assign s0_prdata  = s0_pready ? rdata_q : '0;
    assign s1_pready  = w_resp & grant_q[1];
    assign s1_pslverr = s1_pready & slverr_q;
    assign s1_prdata  = s1_pready ? rdata_q : '0;

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_timer_arbiter.sv
// ============================================================================
// Module      : tb_apb_timer_arbiter
// Description : Scoreboard bench for apb_timer_arbiter with a programmable timer-unit model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_timer_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          s0_psel = 0, s0_penable = 0, s0_pwrite = 0;
    logic [AW-1:0] s0_paddr = '0;
    logic [DW-1:0] s0_pwdata = '0;
    logic          s0_pready, s0_pslverr;
    logic [DW-1:0] s0_prdata;
    logic          s1_psel = 0, s1_penable = 0, s1_pwrite = 0;
    logic [AW-1:0] s1_paddr = '0;
    logic [DW-1:0] s1_pwdata = '0;
    logic          s1_pready, s1_pslverr;
    logic [DW-1:0] s1_prdata;
    logic          m_psel, m_penable, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic          m_pready = 0, m_pslverr = 0;
    logic [DW-1:0] m_prdata = '0;
    logic [1:0]    grant_o;
    logic          timeout_o;

    always #5 HCLK = ~HCLK;

    apb_timer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite),
        .s0_paddr(s0_paddr), .s0_pwdata(s0_pwdata),
        .s0_pready(s0_pready), .s0_pslverr(s0_pslverr), .s0_prdata(s0_prdata),
        .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite),
        .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata),
        .s1_pready(s1_pready), .s1_pslverr(s1_pslverr), .s1_prdata(s1_prdata),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        logic          slverr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
        return {20'hC0DE0, a};
    endfunction

    task automatic push_exp(input int p, input logic [DW-1:0] rd, input logic err);
        exp_t e;
        e.port = p; e.rdata = rd; e.slverr = err;
        exp_q.push_back(e);
    endtask

    task automatic start_req(input int p, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd);
        if (p == 0) begin
            s0_psel = 1'b1; s0_penable = 1'b1; s0_pwrite = wr; s0_paddr = a; s0_pwdata = wd;
        end else begin
            s1_psel = 1'b1; s1_penable = 1'b1; s1_pwrite = wr; s1_paddr = a; s1_pwdata = wd;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((s0_psel || s1_psel) && k < 200) begin
            @(negedge HCLK);
            k++;
        end
        check_eq("drain", {s0_psel, s1_psel}, 2'b00);
        @(negedge HCLK);
    endtask

    // Timer-unit model: answers after wait_cfg wait states unless never_ready is set.
    logic          never_ready = 0;
    logic          err_cfg = 0;
    logic          use_fixed = 0;
    logic [DW-1:0] fixed_rdata = '0;
    int            wait_cfg = 0;
    int            acc_cnt = 0;

    always @(negedge HCLK) begin
        if (m_psel && m_penable && !never_ready && acc_cnt == wait_cfg) begin
            m_pready  = 1'b1;
            m_pslverr = err_cfg;
        end else begin
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
        end
        m_prdata = use_fixed ? fixed_rdata : rd_pattern(m_paddr);
        if (m_psel && m_penable) acc_cnt++;
        else acc_cnt = 0;
    end

    // Completion monitor: pops the scoreboard and releases the finished requester.
    always @(negedge HCLK) begin
        if (HRESETn && (s0_pready || s1_pready)) begin
            exp_t e;
            int   p;
            p = s1_pready ? 1 : 0;
            check_eq("single_ready", s0_pready & s1_pready, 1'b0);
            check_eq("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("port", p, e.port);
                check_eq("grant", grant_o, 2'b01 << e.port);
                check_eq("prdata", p ? s1_prdata : s0_prdata, e.rdata);
                check_eq("pslverr", p ? s1_pslverr : s0_pslverr, e.slverr);
            end
            if (s0_pready) s0_psel = 1'b0;
            if (s1_pready) s1_psel = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, {m_psel, m_penable, m_pwrite, s0_pready, s1_pready,
                                  s0_pslverr, s1_pslverr, grant_o, timeout_o}, '0);
        check_eq({tag, "_maddr"}, m_paddr, '0);
        check_eq({tag, "_mwdata"}, m_pwdata, '0);
        check_eq({tag, "_prdata"}, {s0_prdata, s1_prdata}, '0);
    endtask

    initial begin
        int k;
        int acc;

        repeat (3) @(negedge HCLK);
        check_all_zero("rst");
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Simultaneous requests twice: s0 first, then s1, and again s0 then s1.
        push_exp(0, rd_pattern(12'h010), 1'b0);
        push_exp(1, rd_pattern(12'h020), 1'b0);
        start_req(0, 1'b0, 12'h010, '0);
        start_req(1, 1'b0, 12'h020, '0);
        wait_idle();
        push_exp(0, rd_pattern(12'h030), 1'b0);
        push_exp(1, rd_pattern(12'h040), 1'b0);
        start_req(0, 1'b0, 12'h030, '0);
        start_req(1, 1'b0, 12'h040, '0);
        wait_idle();

        // s0 write with zero wait states: exact phase timing and stable master fields.
        push_exp(0, '0, 1'b0);
        start_req(0, 1'b1, 12'h004, 32'h0000_1234);
        @(negedge HCLK);
        check_eq("w_setup_ctrl", {m_psel, m_penable, m_pwrite, grant_o}, 5'b10101);
        check_eq("w_setup_addr", m_paddr, 12'h004);
        check_eq("w_setup_wdata", m_pwdata, 32'h0000_1234);
        s0_paddr  = 12'hFFF;
        s0_pwdata = 32'hBAD0_BAD0;
        @(negedge HCLK);
        check_eq("w_access_ctrl", {m_psel, m_penable}, 2'b11);
        check_eq("w_access_addr", m_paddr, 12'h004);
        check_eq("w_access_wdata", m_pwdata, 32'h0000_1234);
        @(negedge HCLK);
        check_eq("w_resp_ready", {s0_pready, m_psel}, 2'b10);
        wait_idle();

        // s1 read with five wait states and a fixed data word.
        wait_cfg = 5; use_fixed = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
        push_exp(1, 32'hDEAD_BEEF, 1'b0);
        start_req(1, 1'b0, 12'h008, '0);
        k = 0;
        do begin
            @(negedge HCLK);
            k++;
        end while (!s1_pready && k < 50);
        check_eq("rd_latency", k, 8);
        wait_idle();
        wait_cfg = 0; use_fixed = 1'b0;

        // Slave error is forwarded, then the arbiter is idle again.
        err_cfg = 1'b1;
        push_exp(0, rd_pattern(12'h00C), 1'b1);
        start_req(0, 1'b0, 12'h00C, '0);
        k = 0;
        do begin
            @(negedge HCLK);
            k++;
        end while (!s0_pready && k < 50);
        err_cfg = 1'b0;
        @(negedge HCLK);
        check_eq("err_idle", {grant_o, m_psel, s0_pready}, 4'b0000);
        wait_idle();

        // Timer unit never answers: abort after TO ACCESS cycles.
        never_ready = 1'b1;
        push_exp(0, '0, 1'b1);
        start_req(0, 1'b1, 12'h100, 32'h55);
        k = 0; acc = 0;
        while (!timeout_o && k < 100) begin
            @(negedge HCLK);
            k++;
            if (m_penable) acc++;
        end
        check_eq("to_access_cycles", acc, TO);
        check_eq("to_resp", {timeout_o, m_psel, m_penable, s0_pready}, 4'b1001);
        @(negedge HCLK);
        check_eq("to_pulse_width", timeout_o, 1'b0);
        never_ready = 1'b0;
        wait_idle();

        // Serve s0 so s1 would win the next contest, then reset in the middle of an s1 read.
        push_exp(0, '0, 1'b0);
        start_req(0, 1'b1, 12'h004, 32'h1);
        wait_idle();
        never_ready = 1'b1;
        start_req(1, 1'b0, 12'h008, '0);
        k = 0;
        while (!m_penable && k < 20) begin
            @(negedge HCLK);
            k++;
        end
        check_eq("mid_access_reached", m_penable, 1'b1);
        HRESETn = 1'b0;
        s1_psel = 1'b0;
        @(negedge HCLK);
        check_all_zero("mid_rst");
        HRESETn = 1'b1;
        never_ready = 1'b0;
        @(negedge HCLK);
        push_exp(0, rd_pattern(12'h010), 1'b0);
        push_exp(1, rd_pattern(12'h014), 1'b0);
        start_req(0, 1'b0, 12'h010, '0);
        start_req(1, 1'b0, 12'h014, '0);
        wait_idle();

        check_eq("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
